// File: rtl/pc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_gen : program counter with trap/branch/call redirect and a RAS  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef BRANCH
`define BRANCH 7'b1100011
`endif

module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     STEP      = 1,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap,
  input  logic [6:0]      op,
  input  logic            br_taken,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  localparam int unsigned         c_PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned         c_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(RAS_DEPTH);
  localparam logic [XLEN-1:0]     c_STEP  = XLEN'(STEP);
  localparam logic [6:0]          c_BR_OP = `BRANCH;

  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_top;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_ovf;
  logic               r_unf;

  logic [XLEN-1:0]    w_seq;
  logic [c_PTR_W-1:0] w_top_inc;
  logic               w_empty;
  logic               w_full;
  logic               w_call;
  logic               w_ret;
  logic               w_push;
  logic               w_pop;
  logic               w_replace;

  assign w_seq     = r_pc + c_STEP;
  assign w_top_inc = r_top + c_PTR_W'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == c_FULL);

  // Call/return only take effect on cycles that actually retire (no trap, no stall).
  assign w_call    = is_call && !trap && !stall;
  assign w_ret     = is_ret  && !trap && !stall;
  assign w_replace = w_call && w_ret && !w_empty;
  assign w_push    = w_call && !w_replace;
  assign w_pop     = w_ret && !w_empty && !w_call;

  always_comb begin
    pc_next = w_seq;
    if (trap)                          pc_next = TRAP_VEC;
    else if (stall)                    pc_next = r_pc;
    else if (is_ret && !w_empty)       pc_next = r_ras[r_top];
    else if (is_ret)                   pc_next = addr;
    else if (op == c_BR_OP && br_taken) pc_next = addr;
    else if (is_call)                  pc_next = addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_VEC;
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc <= pc_next;
      if (w_push) begin
        r_top <= w_top_inc;
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + c_CNT_W'(1);
      end else if (w_pop) begin
        r_top <= r_top - c_PTR_W'(1);
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      if (w_ret && w_empty) r_unf <= 1'b1;
    end
  end

  // Entry storage carries no reset; validity is tracked solely by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push)         r_ras[w_top_inc] <= w_seq;
    else if (w_replace) r_ras[r_top]     <= w_seq;
  end

  assign pc        = r_pc;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_gen : directed + random bench for pc_gen (XLEN 32 and 8)     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef BRANCH
`define BRANCH 7'b1100011
`endif

module tb_pc_gen;

  localparam logic [6:0] BR = `BRANCH;

  logic        clk = 1'b0;
  logic        rst_n, stall, trap, br_taken, is_call, is_ret;
  logic [6:0]  op;
  logic [31:0] addr;

  logic [31:0] pc_a, pcn_a;
  logic [7:0]  pc_b, pcn_b;
  logic        emp_a, ful_a, ovf_a, unf_a;
  logic        emp_b, ful_b, ovf_b, unf_b;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: index 0 models the 32-bit instance, index 1 the 8-bit one.
  // The stack is a plain list, oldest at [0], newest at [cnt-1].
  logic [31:0] m_pc [2];
  logic [31:0] m_ras [2][4];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  logic [31:0] n_pc [2];
  logic [31:0] n_ras [2][4];
  int          n_cnt [2];
  bit          n_ovf [2];
  bit          n_unf [2];

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap), .op(op),
    .br_taken(br_taken), .is_call(is_call), .is_ret(is_ret), .addr(addr),
    .pc(pc_a), .pc_next(pcn_a), .ras_empty(emp_a), .ras_full(ful_a),
    .ras_ovf(ovf_a), .ras_unf(unf_a)
  );

  pc_gen #(.XLEN(8), .RESET_VEC(8'h00), .TRAP_VEC(8'hE0)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap), .op(op),
    .br_taken(br_taken), .is_call(is_call), .is_ret(is_ret), .addr(addr[7:0]),
    .pc(pc_b), .pc_next(pcn_b), .ras_empty(emp_b), .ras_full(ful_b),
    .ras_ovf(ovf_b), .ras_unf(unf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void push(input int k, input logic [31:0] v);
    if (n_cnt[k] == 4) begin
      for (int i = 0; i < 3; i++) n_ras[k][i] = n_ras[k][i+1];
      n_ras[k][3] = v;
      n_ovf[k] = 1'b1;
    end else begin
      n_ras[k][n_cnt[k]] = v;
      n_cnt[k]++;
    end
  endfunction

  function automatic void eval(input int k);
    logic [31:0] mask, a, seq, tvec;
    mask = (k == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    tvec = (k == 1) ? 32'h0000_00E0 : 32'h0000_0100;
    a    = addr & mask;
    seq  = (m_pc[k] + 32'd1) & mask;
    n_pc[k] = m_pc[k]; n_cnt[k] = m_cnt[k]; n_ovf[k] = m_ovf[k]; n_unf[k] = m_unf[k];
    for (int i = 0; i < 4; i++) n_ras[k][i] = m_ras[k][i];
    if (trap) n_pc[k] = tvec;
    else if (!stall) begin
      if (is_ret && m_cnt[k] > 0) begin
        n_pc[k] = m_ras[k][m_cnt[k]-1];
        if (is_call) n_ras[k][m_cnt[k]-1] = seq;
        else         n_cnt[k]--;
      end else if (is_ret) begin
        n_pc[k] = a;
        n_unf[k] = 1'b1;
        if (is_call) push(k, seq);
      end else if (op == BR && br_taken) begin
        n_pc[k] = a;
        if (is_call) push(k, seq);
      end else if (is_call) begin
        n_pc[k] = a;
        push(k, seq);
      end else n_pc[k] = seq;
    end
  endfunction

  function automatic void commit();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = n_pc[k]; m_cnt[k] = n_cnt[k]; m_ovf[k] = n_ovf[k]; m_unf[k] = n_unf[k];
      for (int i = 0; i < 4; i++) m_ras[k][i] = n_ras[k][i];
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'd0; m_cnt[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
    end
  endfunction

  task automatic idle_in();
    stall = 1'b0; trap = 1'b0; op = 7'd0; br_taken = 1'b0;
    is_call = 1'b0; is_ret = 1'b0; addr = 32'd0;
  endtask

  // One clock: predict pc_next mid-cycle, then check registered state after the edge.
  task automatic step(input string tag);
    @(negedge clk);
    eval(0); eval(1);
    chk({tag, "_pcn_a"}, pcn_a, n_pc[0]);
    chk({tag, "_pcn_b"}, {24'd0, pcn_b}, n_pc[1]);
    @(posedge clk);
    commit();
    #1;
    chk({tag, "_pc_a"}, pc_a, m_pc[0]);
    chk({tag, "_pc_b"}, {24'd0, pc_b}, m_pc[1]);
    chk({tag, "_emp_a"}, {31'd0, emp_a}, {31'd0, m_cnt[0] == 0});
    chk({tag, "_ful_a"}, {31'd0, ful_a}, {31'd0, m_cnt[0] == 4});
    chk({tag, "_ovf_a"}, {31'd0, ovf_a}, {31'd0, m_ovf[0]});
    chk({tag, "_unf_a"}, {31'd0, unf_a}, {31'd0, m_unf[0]});
    chk({tag, "_emp_b"}, {31'd0, emp_b}, {31'd0, m_cnt[1] == 0});
    chk({tag, "_ful_b"}, {31'd0, ful_b}, {31'd0, m_cnt[1] == 4});
    chk({tag, "_ovf_b"}, {31'd0, ovf_b}, {31'd0, m_ovf[1]});
    chk({tag, "_unf_b"}, {31'd0, unf_b}, {31'd0, m_unf[1]});
  endtask

  initial begin
    logic [31:0] held;
    idle_in();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc_a", pc_a, 32'd0);
    chk("rst_pc_b", {24'd0, pc_b}, 32'd0);
    chk("rst_emp", {31'd0, emp_a}, 32'd1);
    chk("rst_full", {31'd0, ful_a}, 32'd0);
    chk("rst_flags", {30'd0, ovf_a, unf_a}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step("idle");
    chk("seq3", pc_a, 32'd3);
    step("idle"); step("idle");

    op = BR; br_taken = 1'b1; addr = 32'h40; step("br_t");
    chk("br_taken", pc_a, 32'h40);
    addr = 32'h5; step("br_back");
    br_taken = 1'b0; addr = 32'h40; step("br_nt");
    chk("br_not_taken", pc_a, 32'h6);

    br_taken = 1'b1; addr = 32'h10; step("to10");
    idle_in(); is_call = 1'b1; addr = 32'h80; step("call");
    chk("call_tgt", pc_a, 32'h80);
    idle_in();
    for (int i = 0; i < 5; i++) step("body");
    is_ret = 1'b1; addr = 32'h999; step("ret");
    chk("ret_tgt", pc_a, 32'h11);
    chk("ret_empty", {31'd0, emp_a}, 32'd1);

    idle_in();
    for (int i = 0; i < 5; i++) begin
      is_call = 1'b1; addr = 32'h200 + 32'(i) * 32'h10; step("ncall");
    end
    idle_in();
    for (int i = 0; i < 5; i++) begin
      is_ret = 1'b1; addr = 32'h333; step("nret");
    end
    chk("unf_ret_tgt", pc_a, 32'h333);
    chk("ovf_set", {31'd0, ovf_a}, 32'd1);
    chk("unf_set", {31'd0, unf_a}, 32'd1);

    idle_in(); step("pre_stall");
    held = pc_a;
    stall = 1'b1; is_call = 1'b1; addr = 32'h50;
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall_hold", pc_a, held);
    chk("stall_cnt", {31'd0, emp_a}, 32'd1);
    trap = 1'b1; step("trap");
    chk("trap_a", pc_a, 32'h100);
    chk("trap_b", {24'd0, pc_b}, 32'hE0);

    idle_in(); op = BR; br_taken = 1'b1; addr = 32'hFF; step("to_ff");
    idle_in(); step("wrap");
    chk("wrap8", {24'd0, pc_b}, 32'h00);
    chk("nowrap32", pc_a, 32'h100);

    is_call = 1'b1; addr = 32'h300; step("rcall"); step("rcall");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_pc", pc_a, 32'd0);
    chk("midrst_emp", {31'd0, emp_a}, 32'd1);
    chk("midrst_flags", {30'd0, ovf_a, unf_a}, 32'd0);
    idle_in();
    @(posedge clk); #2;
    rst_n = 1'b1;
    step("post_rst");
    chk("post_rst_pc", pc_a, 32'd1);

    for (int i = 0; i < 300; i++) begin
      stall    = ($urandom % 5) == 0;
      trap     = ($urandom % 25) == 0;
      op       = ($urandom % 2) ? BR : 7'($urandom);
      br_taken = $urandom % 2;
      is_call  = ($urandom % 4) == 0;
      is_ret   = ($urandom % 4) == 0;
      addr     = $urandom;
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
